// File: rtl/btle_rx_pkg.sv
// Shared constants, state type and small helpers for the BLE bit-level receive path.
package btle_rx_pkg;

    localparam int unsigned BTLE_AA_LEN     = 32;
    localparam int unsigned BTLE_CRC_LEN    = 24;
    localparam int unsigned BTLE_WHITEN_LEN = 7;
    localparam logic [BTLE_CRC_LEN-1:0] BTLE_CRC_POLY = 24'h00065B;

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_HEADER,
        ST_PAYLOAD,
        ST_CRC
    } btle_rx_state_t;

    // Number of set bits in a 32-bit word.
    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + 6'(v[i]);
        end
        return n;
    endfunction

    // Whitening seed: position 0 = 1, position 1 = channel bit 5 ... position 6 = channel bit 0.
    function automatic logic [BTLE_WHITEN_LEN-1:0] whiten_seed(input logic [5:0] ch);
        return {ch[0], ch[1], ch[2], ch[3], ch[4], ch[5], 1'b1};
    endfunction

    // One step of the x^7+x^4+1 whitening LFSR; output bit is position 6.
    function automatic logic [BTLE_WHITEN_LEN-1:0] whiten_step(input logic [BTLE_WHITEN_LEN-1:0] w);
        return {w[5], w[4], w[3] ^ w[6], w[2], w[1], w[0], w[6]};
    endfunction

endpackage

// File: rtl/btle_rx_packet_capture_crc24.sv
// Bit-serial CRC24 (x^24+x^10+x^9+x^6+x^4+x^3+x+1), MSB-out Galois form.
module btle_crc24_serial
    import btle_rx_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [BTLE_CRC_LEN-1:0] init,
    input  logic                    bit_in,
    input  logic                    bit_en,
    output logic [BTLE_CRC_LEN-1:0] crc
);

    logic feedback;

    assign feedback = crc[BTLE_CRC_LEN-1] ^ bit_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= '0;
        end else if (load) begin
            crc <= init;
        end else if (bit_en) begin
            crc <= {crc[BTLE_CRC_LEN-2:0], 1'b0} ^ (feedback ? BTLE_CRC_POLY : '0);
        end
    end

endmodule

// File: rtl/btle_rx_packet_capture.sv
// BLE receiver back end: access-address search, dewhitening and byte framing.
// Optional CRC24 verdict enabled by defining BTLE_CRC_CHECK_EN.
module btle_rx_packet_capture
    import btle_rx_pkg::*;
#(
    parameter int unsigned AA_MAX_MISMATCH = 1,
    parameter int unsigned MAX_PAYLOAD_LEN = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        phy_bit,
    input  logic        bit_valid,
    input  logic [31:0] access_address,
    input  logic [5:0]  channel_number,
    input  logic [23:0] crc_init,
    output logic        aa_hit,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    output logic        byte_first,
    output logic        byte_last,
    output logic        pkt_done,
    output logic        crc_ok,
    output logic        pkt_abort
);

    btle_rx_state_t state, state_next;

    logic [BTLE_AA_LEN-1:0]     aa_sr;
    logic [BTLE_AA_LEN-1:0]     aa_sr_next;
    logic [5:0]                 search_cnt;
    logic [BTLE_WHITEN_LEN-1:0] whiten;
    logic [7:0]                 shift_byte;
    logic [7:0]                 byte_next;
    logic [2:0]                 bit_cnt;
    logic [7:0]                 byte_cnt;
    logic [7:0]                 pay_len;
    logic [8:0]                 len_diff;
    logic                       dbit;
    logic                       byte_done;
    logic                       hit;
    logic                       emit;
    logic                       emit_first;
    logic                       emit_last;
    logic                       abort;
    logic                       len_load;

    assign dbit       = phy_bit ^ whiten[BTLE_WHITEN_LEN-1];
    assign aa_sr_next = {phy_bit, aa_sr[BTLE_AA_LEN-1:1]};
    assign byte_next  = {dbit, shift_byte[7:1]};
    assign byte_done  = (bit_cnt == 3'd7);
    // Negative difference (bit 8 set) means the length field exceeds the limit.
    assign len_diff   = 9'(MAX_PAYLOAD_LEN) - {1'b0, byte_next};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_SEARCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and framing decisions; nothing moves without bit_valid
    always_comb begin
        state_next = state;
        hit        = 1'b0;
        emit       = 1'b0;
        emit_first = 1'b0;
        emit_last  = 1'b0;
        abort      = 1'b0;
        len_load   = 1'b0;
        if (bit_valid) begin
            unique case (state)
                ST_SEARCH: begin
                    if ((search_cnt >= 6'(BTLE_AA_LEN - 1)) &&
                        (popcount32(aa_sr_next ^ access_address) <= 6'(AA_MAX_MISMATCH))) begin
                        hit        = 1'b1;
                        state_next = ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    if (byte_done) begin
                        if (byte_cnt == 8'd0) begin
                            emit       = 1'b1;
                            emit_first = 1'b1;
                        end else if (len_diff[8]) begin
                            abort      = 1'b1;
                            state_next = ST_SEARCH;
                        end else begin
                            emit       = 1'b1;
                            len_load   = 1'b1;
                            state_next = (byte_next == 8'd0) ? ST_CRC : ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (byte_done) begin
                        emit = 1'b1;
                        if ((byte_cnt + 8'd1) == pay_len) begin
                            state_next = ST_CRC;
                        end
                    end
                end
                ST_CRC: begin
                    if (byte_done) begin
                        emit = 1'b1;
                        if (byte_cnt == 8'd2) begin
                            emit_last  = 1'b1;
                            state_next = ST_SEARCH;
                        end
                    end
                end
                default: state_next = ST_SEARCH;
            endcase
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aa_sr      <= '0;
            search_cnt <= '0;
            whiten     <= '0;
            shift_byte <= '0;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            pay_len    <= '0;
            aa_hit     <= 1'b0;
            byte_out   <= '0;
            byte_valid <= 1'b0;
            byte_first <= 1'b0;
            byte_last  <= 1'b0;
            pkt_done   <= 1'b0;
            pkt_abort  <= 1'b0;
        end else begin
            aa_hit     <= hit;
            byte_valid <= emit;
            byte_first <= emit_first;
            byte_last  <= emit_last;
            pkt_done   <= emit_last;
            pkt_abort  <= abort;
            if (emit) begin
                byte_out <= byte_next;
            end
            if (bit_valid) begin
                if (state == ST_SEARCH) begin
                    aa_sr <= aa_sr_next;
                    if (search_cnt != 6'(BTLE_AA_LEN)) begin
                        search_cnt <= search_cnt + 6'd1;
                    end
                end else begin
                    whiten     <= whiten_step(whiten);
                    shift_byte <= byte_next;
                    bit_cnt    <= bit_cnt + 3'd1;
                    if (byte_done) begin
                        byte_cnt <= byte_cnt + 8'd1;
                    end
                end
                if (len_load) begin
                    pay_len <= byte_next;
                end
                if (hit) begin
                    whiten  <= whiten_seed(channel_number);
                    bit_cnt <= '0;
                end
                if (state_next != state) begin
                    byte_cnt <= '0;
                end
                // Leaving a packet: require 32 fresh bits before the next hit.
                if ((state != ST_SEARCH) && (state_next == ST_SEARCH)) begin
                    search_cnt <= '0;
                end
            end
        end
    end

`ifdef BTLE_CRC_CHECK_EN
    logic [BTLE_CRC_LEN-1:0] crc_val;
    logic [4:0]              crc_idx;
    logic                    crc_bit_ok;
    logic                    crc_match;

    btle_crc24_serial u_crc (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (hit),
        .init   (crc_init),
        .bit_in (dbit),
        .bit_en (bit_valid && ((state == ST_HEADER) || (state == ST_PAYLOAD))),
        .crc    (crc_val)
    );

    // Received CRC bit k is compared against computed position 23-k.
    assign crc_idx    = 5'd23 - {byte_cnt[1:0], bit_cnt};
    assign crc_bit_ok = (dbit == crc_val[crc_idx]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_match <= 1'b0;
            crc_ok    <= 1'b0;
        end else if (bit_valid) begin
            if (hit) begin
                crc_match <= 1'b1;
            end else if ((state == ST_CRC) && !crc_bit_ok) begin
                crc_match <= 1'b0;
            end
            if (emit_last) begin
                crc_ok <= crc_match & crc_bit_ok;
            end
        end
    end
`else
    logic unused_crc_init;

    assign unused_crc_init = ^crc_init;
    assign crc_ok          = 1'b0;
`endif

endmodule

// File: tb/tb_btle_rx_packet_capture.sv
// Scoreboard bench for btle_rx_packet_capture: bit-exact whitening/CRC model drives the DUT.
module tb_btle_rx_packet_capture;

    localparam logic [31:0] AA = 32'h8E89BED6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        phy_bit = 1'b0;
    logic        bit_valid = 1'b0;
    logic [31:0] access_address = AA;
    logic [5:0]  channel_number = 6'd0;
    logic [23:0] crc_init = 24'd0;
    logic        aa_hit;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_first;
    logic        byte_last;
    logic        pkt_done;
    logic        crc_ok;
    logic        pkt_abort;

    btle_rx_packet_capture #(
        .AA_MAX_MISMATCH (1),
        .MAX_PAYLOAD_LEN (37)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .phy_bit        (phy_bit),
        .bit_valid      (bit_valid),
        .access_address (access_address),
        .channel_number (channel_number),
        .crc_init       (crc_init),
        .aa_hit         (aa_hit),
        .byte_out       (byte_out),
        .byte_valid     (byte_valid),
        .byte_first     (byte_first),
        .byte_last      (byte_last),
        .pkt_done       (pkt_done),
        .crc_ok         (crc_ok),
        .pkt_abort      (pkt_abort)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       first;
        logic       last;
        logic       crc_ok;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_fail = 0;
    longint     cyc = 0;
    int         hit_cnt = 0;
    int         abort_cnt = 0;
    int         done_cnt = 0;
    longint     last_hit_cyc = -1;
    longint     aa_end_cyc = 0;
    int         exp_hits = 0;
    int         exp_aborts = 0;
    int         exp_done = 0;
    logic [7:0] pkt [0:63];
    int         pkt_n = 0;
    logic       good_crc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pop the scoreboard whenever the DUT presents a byte
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (aa_hit) begin
                hit_cnt++;
                last_hit_cyc = cyc;
            end
            if (pkt_abort) abort_cnt++;
            if (pkt_done) done_cnt++;
            if (byte_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", 32'(byte_out), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("byte_out", 32'(byte_out), 32'(e.data));
                    check("byte_first", 32'(byte_first), 32'(e.first));
                    check("byte_last", 32'(byte_last), 32'(e.last));
                    check("pkt_done", 32'(pkt_done), 32'(e.last));
                    if (e.last) check("crc_ok", 32'(crc_ok), 32'(e.crc_ok));
                end
            end else if (pkt_done || byte_first || byte_last) begin
                check("flags_without_byte_valid", 32'({pkt_done, byte_first, byte_last}), 32'd0);
            end
        end
    end

    task automatic send_bit(input logic b, input int max_gap);
        int g;
        g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        repeat (g) begin
            @(negedge clk);
            bit_valid = 1'b0;
            phy_bit   = 1'($urandom_range(1, 0));
        end
        @(negedge clk);
        bit_valid = 1'b1;
        phy_bit   = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bit_valid = 1'b0;
        end
    endtask

    task automatic set_pkt(input logic [7:0] h0, input logic [7:0] len, input int npay, input logic [7:0] seed);
        pkt[0] = h0;
        pkt[1] = len;
        for (int i = 0; i < npay; i++) pkt[i+2] = seed + 8'(i * 8'h11);
        pkt_n = npay + 2;
    endtask

    // Builds header/payload/CRC, whitens it with an independent model and transmits it.
    task automatic send_packet(input logic [5:0] ch, input logic [23:0] ci, input logic [31:0] aa_flip,
                               input int crc_flip, input int cut_bits, input int max_gap,
                               input bit expect_hit, input bit expect_abort);
        logic [7:0]  stream [0:66];
        logic [23:0] c;
        logic [31:0] aa_tx;
        logic [7:0]  pre;
        logic [6:0]  p;
        logic [6:0]  q;
        logic        fb;
        logic        wb;
        exp_t        e;
        int          nb;
        int          limit;
        c = ci;
        for (int i = 0; i < pkt_n; i++) begin
            stream[i] = pkt[i];
            for (int k = 0; k < 8; k++) begin
                fb = c[23] ^ pkt[i][k];
                c  = {c[22:0], 1'b0};
                if (fb) c = c ^ 24'h00065B;
            end
        end
        for (int j = 0; j < 3; j++)
            for (int k = 0; k < 8; k++)
                stream[pkt_n+j][k] = c[23 - (8*j + k)];
        if (crc_flip >= 0) stream[pkt_n + crc_flip/8][crc_flip%8] = ~stream[pkt_n + crc_flip/8][crc_flip%8];
`ifdef BTLE_CRC_CHECK_EN
        good_crc = (crc_flip < 0);
`else
        good_crc = 1'b0;
`endif
        nb    = expect_abort ? 2 : pkt_n + 3;
        limit = (cut_bits >= 0) ? cut_bits : nb * 8;
        channel_number = ch;
        crc_init       = ci;
        pre   = 8'hAA;
        aa_tx = AA ^ aa_flip;
        for (int k = 0; k < 8; k++) send_bit(pre[k], max_gap);
        for (int k = 0; k < 32; k++) send_bit(aa_tx[k], max_gap);
        aa_end_cyc = cyc;
        if (expect_hit) begin
            exp_hits++;
            p[0] = 1'b1;
            for (int i = 1; i < 7; i++) p[i] = ch[6-i];
            for (int i = 0; i < nb; i++) begin
                if (((i + 1) * 8 <= limit) && !(expect_abort && i == 1)) begin
                    e.data   = stream[i];
                    e.first  = (i == 0);
                    e.last   = (i == nb - 1) && !expect_abort;
                    e.crc_ok = good_crc;
                    exp_q.push_back(e);
                end
                for (int k = 0; k < 8; k++) begin
                    if (i * 8 + k < limit) begin
                        wb = p[6];
                        send_bit(stream[i][k] ^ wb, max_gap);
                        q[0] = p[6];
                        q[1] = p[0];
                        q[2] = p[1];
                        q[3] = p[2];
                        q[4] = p[3] ^ p[6];
                        q[5] = p[4];
                        q[6] = p[5];
                        p    = q;
                    end
                end
            end
        end
    endtask

    task automatic after_packet(input string name, input bit hit_expected);
        idle(4);
        check({name, "_hits"}, 32'(hit_cnt), 32'(exp_hits));
        check({name, "_aborts"}, 32'(abort_cnt), 32'(exp_aborts));
        check({name, "_done"}, 32'(done_cnt), 32'(exp_done));
        check({name, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
        if (hit_expected) check({name, "_hit_cycle"}, 32'(last_hit_cyc), 32'(aa_end_cyc + 1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({aa_hit, byte_valid, byte_first, byte_last, pkt_done, crc_ok, pkt_abort}), 32'd0);
        check("reset_byte_out", 32'(byte_out), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Exact AA, advertising packet on channel 37
        set_pkt(8'h02, 8'h06, 6, 8'h10);
        exp_done++;
        send_packet(6'd37, 24'h555555, 32'd0, -1, -1, 0, 1'b1, 1'b0);
        after_packet("exact_aa", 1'b1);

        // One AA bit flipped is tolerated
        exp_done++;
        send_packet(6'd37, 24'h555555, 32'h0000_0080, -1, -1, 0, 1'b1, 1'b0);
        after_packet("aa_1flip", 1'b1);

        // Two AA bits flipped: no hit
        send_packet(6'd37, 24'h555555, 32'h0010_0008, -1, -1, 0, 1'b0, 1'b0);
        after_packet("aa_2flip", 1'b0);

        // Corrupted CRC, then a clean packet; crc_ok holds between verdicts
        exp_done++;
        send_packet(6'd37, 24'h555555, 32'd0, 10, -1, 0, 1'b1, 1'b0);
        after_packet("bad_crc", 1'b1);
        idle(5);
        check("crc_ok_hold_bad", 32'(crc_ok), 32'd0);
        exp_done++;
        send_packet(6'd37, 24'h555555, 32'd0, -1, -1, 0, 1'b1, 1'b0);
        after_packet("good_crc", 1'b1);
        idle(5);
        check("crc_ok_hold_good", 32'(crc_ok), 32'(good_crc));

        // Length field 0x40 exceeds the limit of 37
        set_pkt(8'h02, 8'h40, 0, 8'h00);
        exp_aborts++;
        send_packet(6'd37, 24'h555555, 32'd0, -1, -1, 0, 1'b1, 1'b1);
        after_packet("len_abort", 1'b1);

        // Zero-length packet after the abort
        set_pkt(8'h01, 8'h00, 0, 8'h00);
        exp_done++;
        send_packet(6'd12, 24'h123456, 32'd0, -1, -1, 0, 1'b1, 1'b0);
        after_packet("post_abort_len0", 1'b1);

        // Random bit_valid gaps
        set_pkt(8'h02, 8'h06, 6, 8'h10);
        exp_done++;
        send_packet(6'd37, 24'h555555, 32'd0, -1, -1, 5, 1'b1, 1'b0);
        after_packet("gaps", 1'b1);

        // Reset in the middle of the payload
        set_pkt(8'h42, 8'h05, 5, 8'hA0);
        send_packet(6'd38, 24'hABCDEF, 32'd0, -1, 35, 0, 1'b1, 1'b0);
        @(negedge clk);
        bit_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midreset_outputs", 32'({aa_hit, byte_valid, byte_first, byte_last, pkt_done, crc_ok, pkt_abort}), 32'd0);
        check("midreset_byte_out", 32'(byte_out), 32'd0);
        check("midreset_queue", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        after_packet("midreset", 1'b0);

        // Clean packet after reset
        set_pkt(8'h06, 8'h03, 3, 8'h5A);
        exp_done++;
        send_packet(6'd39, 24'h555555, 32'd0, -1, -1, 0, 1'b1, 1'b0);
        after_packet("post_reset", 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
